// File: rtl/dac_stream_pkg.sv
// -----------------------------------------------------------------------------
// dac_stream_pkg
//   Shared definitions for the streaming DAC output engine:
//     - uf_mode_e : what the output register does when a sample tick finds the
//                   FIFO empty (hold the last code, or load midscale)
//     - level_w() : width of a FIFO occupancy count able to represent 0..depth
//     - midscale(): offset-binary midscale code for a given channel width
// -----------------------------------------------------------------------------
package dac_stream_pkg;

  typedef enum logic {
    UF_HOLD = 1'b0,   // keep the last code on the DAC
    UF_MID  = 1'b1    // park the DAC at midscale
  } uf_mode_e;

  // Occupancy must reach 'depth' itself, hence one bit beyond the address.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // {1'b1, {data_w-1{1'b0}}}, returned in a 32-bit container; callers size it.
  function automatic logic [31:0] midscale(input int data_w);
    return 32'd1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/dac_stream_out_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. o_data always shows the oldest
//   entry; a pop simply advances the read pointer. Pointers carry one extra
//   MSB so full and empty are distinguished without a separate counter, and
//   full/empty/level are registered from the next-state pointers so they are
//   glitch-free and valid in the cycle after the push/pop edge.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     i_push       write i_data (ignored while full)
//     i_data       write data, WIDTH bits
//     i_pop        discard the head entry (ignored while empty)
//     o_data       head entry (undefined while empty)
//     o_full       registered full flag
//     o_empty      registered empty flag
//     o_level      registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
  import dac_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16     // power of two, >= 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [level_w(DEPTH)-1:0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = level_w(DEPTH);   // address bits plus wrap bit

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_full;
  logic             r_empty;
  logic [PW-1:0]    r_level;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_rd_nxt;
  logic [PW-1:0]    w_level_nxt;
  logic             w_full_nxt;
  logic             w_empty_nxt;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop  && !r_empty;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    w_wr_nxt    = r_wr_ptr + PW'(w_push);
    w_rd_nxt    = r_rd_ptr + PW'(w_pop);
    w_level_nxt = w_wr_nxt - w_rd_nxt;
    w_empty_nxt = (w_wr_nxt == w_rd_nxt);
    // Same slot, opposite lap: the writer is a whole buffer ahead.
    w_full_nxt  = (w_wr_nxt[PW-1] != w_rd_nxt[PW-1]) &&
                  (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_full   <= w_full_nxt;
      r_empty  <= w_empty_nxt;
      r_level  <= w_level_nxt;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and a resettable array would not map to RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/dac_stream_out.sv
// -----------------------------------------------------------------------------
// dac_stream_out
//   Streaming DAC output engine. Samples arriving on the s_* handshake are
//   buffered in a FIFO and replayed to CHANNELS parallel DACs, one sample per
//   programmable period, together with a registered DAC latch clock.
//
//   Optional feature (compile-time macro DAC_STREAM_TWOS_COMP_EN):
//     defined   - input channels are two's complement; the MSB of every
//                 channel is inverted on its way into dac_data (offset binary)
//     undefined - input channels are already offset binary and pass unchanged
//   In both builds the underflow idle code is midscale on every channel.
//
//   Ports
//     hclk, hresetn  clock, asynchronous active-low reset
//     enable         run the sample clock; low forces the divider idle
//     clk_div        sample period minus one in hclk cycles (0 acts as 1)
//     uflow_mode     0: hold last code on underflow, 1: output midscale
//     s_valid/s_ready/s_data  sample stream, channel 0 in the LSBs
//     level          registered FIFO occupancy
//     uflow          sticky underflow flag
//     uflow_clr      clear uflow (a simultaneous underflow wins)
//     dac_data       registered DAC codes, all channels update together
//     dac_clk        registered DAC latch clock, DACs latch on its rise
// -----------------------------------------------------------------------------
module dac_stream_out
  import dac_stream_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CHANNELS   = 1,    // 1..4
  parameter int FIFO_DEPTH = 16,   // power of two, >= 4
  parameter int DIV_W      = 16
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic                             enable,
  input  logic [DIV_W-1:0]                 clk_div,
  input  logic                             uflow_mode,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [CHANNELS*DATA_W-1:0]       s_data,
  output logic [level_w(FIFO_DEPTH)-1:0]   level,
  output logic                             uflow,
  input  logic                             uflow_clr,
  output logic [CHANNELS*DATA_W-1:0]       dac_data,
  output logic                             dac_clk
);

  localparam int DW_ALL = CHANNELS * DATA_W;
  localparam int LVL_W  = level_w(FIFO_DEPTH);

  localparam logic [DATA_W-1:0] MID = DATA_W'(midscale(DATA_W));

  // Per-channel XOR pattern applied when a sample is loaded into dac_data.
  // Flipping the MSB maps two's complement onto offset binary.
`ifdef DAC_STREAM_TWOS_COMP_EN
  localparam logic [DATA_W-1:0] CONV_XOR = MID;
`else
  localparam logic [DATA_W-1:0] CONV_XOR = '0;
`endif

  localparam logic [DW_ALL-1:0] CONV_MASK = {CHANNELS{CONV_XOR}};
  localparam logic [DW_ALL-1:0] IDLE_CODE = {CHANNELS{MID}};

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [DW_ALL-1:0] w_fifo_data;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [LVL_W-1:0]  w_fifo_level;
  logic              w_pop;

  sync_fifo #(
    .WIDTH (DW_ALL),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (hclk),
    .rst_n   (hresetn),
    .i_push  (s_valid),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  assign s_ready = !w_fifo_full;
  assign level   = w_fifo_level;

  // ---------------------------------------------------------------------------
  // Sample-period divider
  //   r_cnt runs 0..r_div_q; the cycle where it equals r_div_q is the tick,
  //   and the tick edge updates dac_data. r_run remembers that enable was
  //   already high, so the first enabled edge (re)starts a fresh period and
  //   the first tick lands div_q+1 cycles after it.
  // ---------------------------------------------------------------------------
  logic              r_run;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div_q;
  logic              r_dac_clk;

  logic [DIV_W-1:0]  w_div_in;
  logic              w_tick;
  logic [DIV_W-1:0]  w_cnt_nxt;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [DIV_W:0]    w_half_nxt;
  logic              w_dac_clk_nxt;

  // A zero divider would make every cycle a tick; clamp to a period of 2.
  assign w_div_in = (clk_div == '0) ? DIV_W'(1) : clk_div;
  assign w_tick   = r_run && (r_cnt == r_div_q);

  always_comb begin
    w_cnt_nxt = r_cnt + DIV_W'(1);
    w_div_nxt = r_div_q;
    if (!enable) begin
      w_cnt_nxt = '0;
    end else if (!r_run || w_tick) begin
      // Period boundary: a new clk_div only takes effect from here on.
      w_cnt_nxt = '0;
      w_div_nxt = w_div_in;
    end
    // Low for ceil(P/2) cycles starting at the data update, then high for
    // floor(P/2), with P = div+1. ceil(P/2) = (div+2)/2; one extra bit keeps
    // the sum from overflowing at the maximum divider.
    w_half_nxt    = ({1'b0, w_div_nxt} + (DIV_W+1)'(2)) >> 1;
    w_dac_clk_nxt = enable && ({1'b0, w_cnt_nxt} >= w_half_nxt);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_run     <= 1'b0;
      r_cnt     <= '0;
      r_div_q   <= DIV_W'(1);
      r_dac_clk <= 1'b0;
    end else begin
      r_run     <= enable;
      r_cnt     <= w_cnt_nxt;
      r_div_q   <= w_div_nxt;
      r_dac_clk <= w_dac_clk_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and underflow reporting
  // ---------------------------------------------------------------------------
  logic [DW_ALL-1:0] r_dac_data;
  logic              r_uflow;
  logic              w_uf_set;
  uf_mode_e          w_uf_mode;

  assign w_uf_mode = uf_mode_e'(uflow_mode);
  assign w_pop     = w_tick && !w_fifo_empty;
  assign w_uf_set  = w_tick &&  w_fifo_empty;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_dac_data <= '0;
    end else if (w_pop) begin
      r_dac_data <= w_fifo_data ^ CONV_MASK;
    end else if (w_uf_set && (w_uf_mode == UF_MID)) begin
      r_dac_data <= IDLE_CODE;
    end
  end

  // Set has priority so an underflow coinciding with a clear is not lost.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_uflow <= 1'b0;
    end else if (w_uf_set) begin
      r_uflow <= 1'b1;
    end else if (uflow_clr) begin
      r_uflow <= 1'b0;
    end
  end

  assign dac_data = r_dac_data;
  assign dac_clk  = r_dac_clk;
  assign uflow    = r_uflow;

endmodule

// File: tb/tb_dac_stream_out.sv
// -----------------------------------------------------------------------------
// tb_dac_stream_out
//   Self-checking bench for dac_stream_out (DATA_W=8, CHANNELS=4, depth 16).
//   A behavioural model (sample queue + period phase counter) runs alongside
//   the DUT and is compared against it every cycle; directed sequences add
//   checks against fixed expected values for the key scenarios.
// -----------------------------------------------------------------------------
module tb_dac_stream_out;

  localparam int DATA_W   = 8;
  localparam int CHANNELS = 4;
  localparam int DEPTH    = 16;
  localparam int DIV_W    = 16;
  localparam int DW       = DATA_W * CHANNELS;

  localparam logic [DW-1:0] IDLE = 32'h8080_8080;

  logic              hclk       = 1'b0;
  logic              hresetn    = 1'b0;
  logic              enable     = 1'b0;
  logic [DIV_W-1:0]  clk_div    = '0;
  logic              uflow_mode = 1'b0;
  logic              s_valid    = 1'b0;
  logic [DW-1:0]     s_data     = '0;
  logic              uflow_clr  = 1'b0;
  logic              s_ready;
  logic [4:0]        level;
  logic              uflow;
  logic [DW-1:0]     dac_data;
  logic              dac_clk;

  dac_stream_out #(
    .DATA_W     (DATA_W),
    .CHANNELS   (CHANNELS),
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .enable     (enable),
    .clk_div    (clk_div),
    .uflow_mode (uflow_mode),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .level      (level),
    .uflow      (uflow),
    .uflow_clr  (uflow_clr),
    .dac_data   (dac_data),
    .dac_clk    (dac_clk)
  );

  always #5 hclk = ~hclk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Input sample -> DAC code, channel by channel in plain arithmetic.
  function automatic logic [DW-1:0] to_dac(input logic [DW-1:0] x);
    longint r;
    longint v;
    r = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      v = (longint'(x) >> (c * DATA_W)) % (longint'(1) << DATA_W);
`ifdef DAC_STREAM_TWOS_COMP_EN
      v = (v + (longint'(1) << (DATA_W - 1))) % (longint'(1) << DATA_W);
`endif
      r = r + (v << (c * DATA_W));
    end
    return DW'(r);
  endfunction

  logic [DW-1:0] m_q[$];
  int            m_phase = 0;   // cycles elapsed in the current period
  int            m_per   = 1;   // effective divider for the current period
  bit            m_run   = 0;
  bit            m_clk   = 0;
  bit            m_uflow = 0;
  logic [DW-1:0] m_dac   = '0;

  always @(posedge hclk or negedge hresetn) begin : model
    bit tick;
    bit was_empty;
    bit accept;
    int p;
    if (!hresetn) begin
      m_q.delete();
      m_phase = 0;
      m_per   = 1;
      m_run   = 0;
      m_clk   = 0;
      m_uflow = 0;
      m_dac   = '0;
    end else begin
      tick      = m_run && (m_phase == m_per);
      was_empty = (m_q.size() == 0);
      accept    = s_valid && (m_q.size() < DEPTH);
      if (tick) begin
        if (!was_empty)      m_dac = to_dac(m_q.pop_front());
        else if (uflow_mode) m_dac = IDLE;
      end
      if (tick && was_empty) m_uflow = 1;
      else if (uflow_clr)    m_uflow = 0;
      if (accept) m_q.push_back(s_data);
      if (!enable) begin
        m_run   = 0;
        m_phase = 0;
      end else if (!m_run || tick) begin
        m_run   = 1;
        m_per   = (clk_div == 0) ? 1 : int'(clk_div);
        m_phase = 0;
      end else begin
        m_phase++;
      end
      p     = m_per + 1;
      m_clk = enable && (m_phase >= p - p / 2);
    end
  end

  bit mon_en = 0;

  always @(negedge hclk) begin
    if (mon_en) begin
      check("mon_dac_data", dac_data, m_dac);
      check("mon_dac_clk",  dac_clk,  m_clk);
      check("mon_uflow",    uflow,    m_uflow);
      check("mon_level",    level,    m_q.size());
      check("mon_s_ready",  s_ready,  m_q.size() < DEPTH);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  // Advance until the edge on which dac_clk falls (data update edge).
  task automatic sync_fall(output bit ok);
    bit prev;
    ok   = 0;
    prev = dac_clk;
    for (int i = 0; i < 64; i++) begin
      step();
      if (prev && !dac_clk) begin
        ok = 1;
        break;
      end
      prev = dac_clk;
    end
  endtask

  // Count cycles to the next falling edge of dac_clk; -1 on timeout.
  task automatic next_fall(output int n);
    bit prev;
    prev = dac_clk;
    n    = -1;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (prev && !dac_clk) begin
        n = i;
        break;
      end
      prev = dac_clk;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    logic [DW-1:0] exp_data;
    logic [DW-1:0] ch_exp;
    bit            ok;
    bit            seen;
    int            n;

    step(2);
    check("rst_dac_data", dac_data, 0);
    check("rst_dac_clk",  dac_clk,  0);
    check("rst_uflow",    uflow,    0);
    check("rst_level",    level,    0);
    hresetn = 1'b1;
    step();
    check("rst_s_ready",  s_ready,  1);
    mon_en = 1;

    // Prefill while idle, then run at period 4.
    push(32'h10);
    push(32'h20);
    push(32'h30);
    check("prefill_level", level, 3);
    clk_div = 3;
    enable  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      exp_data = (k >= 12) ? to_dac(32'h30) :
                 (k >= 8)  ? to_dac(32'h20) :
                 (k >= 4)  ? to_dac(32'h10) : '0;
      check("seq_dac_data", dac_data, exp_data);
      check("seq_dac_clk",  dac_clk,  (k % 4) >= 2);
      check("seq_uflow",    uflow,    0);
    end

    // Underflow: hold, then midscale, then clear vs. simultaneous set.
    step();                                   // k = 16
    check("uf_hold_flag", uflow, 1);
    check("uf_hold_data", dac_data, to_dac(32'h30));
    uflow_mode = 1'b1;
    step(4);                                  // k = 20
    check("uf_mid_data", dac_data, IDLE);
    step();                                   // k = 21
    uflow_clr = 1'b1;
    step();                                   // k = 22
    uflow_clr = 1'b0;
    check("uf_clr", uflow, 0);
    step();                                   // k = 23
    uflow_clr = 1'b1;
    step();                                   // k = 24, underflow tick
    uflow_clr = 1'b0;
    check("uf_set_wins", uflow, 1);

    // Four channels update together.
`ifdef DAC_STREAM_TWOS_COMP_EN
    ch_exp = 32'hC4B3_A291;
`else
    ch_exp = 32'h4433_2211;
`endif
    push(32'h4433_2211);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dac_data !== IDLE) begin
        seen = 1;
        break;
      end
    end
    check("ch4_seen", seen, 1);
    check("ch4_data", dac_data, ch_exp);

    // Divider: 0 behaves as 1, and mid-period changes wait for the boundary.
    uflow_mode = 1'b0;
    clk_div    = 0;
    sync_fall(ok);
    check("div0_sync", ok, 1);
    next_fall(n);
    check("div0_period", n, 2);
    clk_div = 3;
    sync_fall(ok);
    check("div3_sync", ok, 1);
    next_fall(n);
    check("div3_period", n, 4);
    step();
    clk_div = 5;
    next_fall(n);
    check("div_mid_change_cur", n + 1, 4);
    next_fall(n);
    check("div_mid_change_next", n, 6);

    // Fill to full while idle; the 17th sample is refused.
    enable = 1'b0;
    step(2);
    s_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      s_data = $urandom;
      step();
    end
    check("full_level",   level,   16);
    check("full_s_ready", s_ready, 0);
    s_data = 32'hDEAD_BEEF;
    step();
    s_valid = 1'b0;
    check("full_reject_level", level, 16);
    clk_div = 1;
    enable  = 1'b1;
    seen    = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (level != 16) begin
        seen = 1;
        break;
      end
    end
    check("drain_seen",    seen,    1);
    check("drain_level",   level,   15);
    check("drain_s_ready", s_ready, 1);

    // Asynchronous reset mid-stream at level 5.
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      if (level == 5) begin
        seen = 1;
        break;
      end
      step();
    end
    check("pre_rst_level", level, 5);
    hresetn = 1'b0;
    #2;
    check("arst_dac_data", dac_data, 0);
    check("arst_dac_clk",  dac_clk,  0);
    check("arst_uflow",    uflow,    0);
    check("arst_level",    level,    0);
    check("arst_s_ready",  s_ready,  1);
    hresetn = 1'b1;
    step();
    check("post_rst_level",   level,   0);
    check("post_rst_dac_clk", dac_clk, 0);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      s_valid   = ($urandom_range(0, 2) != 0);
      s_data    = $urandom;
      uflow_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) enable     = ~enable;
      if ($urandom_range(0, 19) == 0) clk_div    = DIV_W'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) uflow_mode = ~uflow_mode;
      if ($urandom_range(0, 399) == 0) begin
        hresetn = 1'b0;
        step();
        hresetn = 1'b1;
      end else begin
        step();
      end
    end
    s_valid   = 1'b0;
    uflow_clr = 1'b0;
    step(2);
    mon_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dac_stream_out.md
# dac_stream_out

Parametrised streaming DAC output engine: it buffers samples from the processor system's streaming interface and replays them to one or more parallel DACs at a programmable sample rate. It also generates the DAC latch clock. It supersedes the fixed 8-bit single-channel `dac_data`/`dac_clk` path and sits inside the processor-system wrapper on the `hclk` domain. It adds buffering, rate control, multi-channel output and underflow reporting.

## Interface
- `DATA_W`, 8, bits per DAC channel
- `CHANNELS`, 1, number of DAC channels updated in lockstep (1..4)
- `FIFO_DEPTH`, 16, sample FIFO depth in samples; power of two, ≥4
- `DIV_W`, 16, width of the sample-period divider

Clocking: one clock; reset is asynchronous and active-low.
- `hclk`  in  1  sole clock
- `hresetn`  in  1  async active-low reset
- `enable`  in  1  run sample clock; low = idle
- `clk_div`  in  DIV_W  sample period minus one, in `hclk` cycles (0 treated as 1)
- `uflow_mode`  in  1  0 = hold last sample on underflow; 1 = output midscale
- `s_valid`  in  1  sample valid
- `s_ready`  out  1  FIFO can accept
- `s_data`  in  CHANNELS*DATA_W  one sample per channel, channel 0 in LSBs
- `level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- `uflow`  out  1  sticky underflow flag
- `uflow_clr`  in  1  clear `uflow`
- `dac_data`  out  CHANNELS*DATA_W  registered DAC codes
- `dac_clk`  out  1  registered DAC latch clock; DACs latch on the rising edge

## Operation
- FIFO push when `s_valid && s_ready`.
- `s_ready = !full`. There is no push on a full FIFO, so push and pop on full cannot occur.
- Divider counter `cnt` counts 0..`div_q`.
- `div_q` is `max(clk_div,1)`, captured at the enable rising edge and at every tick. Mid-period changes to `clk_div` take effect at the next period.
- A tick occurs when `cnt == div_q`. `cnt` then wraps to 0.
- On a tick:
  - FIFO not empty: pop the FIFO into `dac_data`.
  - FIFO empty: set `uflow`. `dac_data` holds (`uflow_mode=0`) or loads midscale `{1'b1,{DATA_W-1{1'b0}}}` on every channel (`uflow_mode=1`).
- `uflow_clr` clears `uflow`. A set on the same cycle wins.
- `enable` low:
  - `cnt` is forced to 0 and `dac_clk` to 0.
  - `dac_data` holds its value.
  - The FIFO keeps accepting samples, so software can prefill before enabling.
- `enable` rising: the first tick occurs `div_q+1` cycles later.

## Timing
- Reset values:
  - `dac_data` = 0, `dac_clk` = 0, `uflow` = 0, `level` = 0.
  - `s_ready` = 1 from the first clock edge after reset release.
  - FIFO is empty and `cnt` = 0.
- Period P = `div_q+1` cycles.
- `dac_clk` goes low on the edge that updates `dac_data`. It stays low for ceil(P/2) cycles and high for floor(P/2) cycles. Data is therefore stable ≥1 cycle before each rising edge.
- `level` is registered and updates the cycle after a push or pop. A simultaneous push and pop leave it unchanged.
- Latency from push into an empty FIFO: the sample is poppable 1 cycle after the push edge. It is visible on `dac_data` at the next tick that is ≥1 cycle later.
- Reset mid-operation: all state returns to reset values immediately (async). FIFO contents are discarded.

## Configuration
- Macro: `DAC_STREAM_TWOS_COMP_EN`.
- Defined:
  - `s_data` channels are two's complement. The MSB of each channel is inverted when loaded into `dac_data`, giving offset binary.
  - The `uflow_mode=1` idle code is the converted value of input 0, i.e. midscale 0x80 for `DATA_W`=8.
- Undefined:
  - Data passes through unchanged (offset binary in).
  - Midscale is output directly.

## Structure
- Package `dac_stream_pkg`:
  - midscale constant function of `DATA_W`
  - the level-width helper
  - the underflow-mode enum (`UF_HOLD`, `UF_MID`)
- Sub-module `sync_fifo`:
  - parameters: width `CHANNELS*DATA_W`, depth `FIFO_DEPTH`
  - registered `full`/`empty`/`level`
  - pointer wrap via an extra MSB
- Top of the block holds the divider, `dac_clk` generation, output register and underflow logic.

## Test plan
- Reset, `DATA_W`=8, `CHANNELS`=1: push 0x10,0x20,0x30 with `enable`=0, then `clk_div`=3, `enable`=1 → `dac_data` steps 0x10,0x20,0x30 every 4 cycles; `dac_clk` low 2 / high 2; `uflow` stays 0 through the third sample.
- Continue with no pushes: `uflow_mode`=0 → 4th tick sets `uflow`, `dac_data` holds 0x30. Switch to `uflow_mode`=1 → next tick gives 0x80. Pulse `uflow_clr` → 0, unless a tick underflows the same cycle (stays 1).
- Push 16 samples with `enable`=0 → `level`=16, `s_ready`=0. 17th `s_valid` is not accepted. One tick → `level`=15, `s_ready`=1.
- `clk_div`=0 → behaves as 1: period 2, `dac_clk` toggles every cycle. Change `clk_div` 3→5 mid-period → current period stays 4, following periods are 6.
- `CHANNELS`=4, push 0x44332211 → channels 0..3 = 0x11,0x22,0x33,0x44 update on the same edge. With `DAC_STREAM_TWOS_COMP_EN` defined → 0x91,0xA2,0xB3,0xC4.
- Assert `hresetn` low mid-stream with `level`=5 → all outputs take reset values asynchronously; after release `level`=0 and `dac_clk`=0.
